// File: rtl/queue_arbiter.sv
// Write-side arbiter and read sequencer for the shared 8-bit queue, with occupancy tracking.
// Optional build macro QARB_FIXED_PRIO_EN: fixed lowest-index priority instead of round-robin.
module queue_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned DEPTH   = 8,
    parameter int unsigned CW      = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [NUM_REQ*8-1:0] req_data,
    output logic [NUM_REQ-1:0]   gnt,
    output logic [7:0]           q_in_data,
    output logic                 q_write_en,
    output logic                 q_read_en,
    input  logic [7:0]           q_out_data,
    input  logic                 q_empty,
    input  logic                 pop_req,
    output logic                 pop_valid,
    output logic [7:0]           pop_data,
    input  logic                 pop_ack,
    output logic [CW-1:0]        count,
    output logic                 full
);

    localparam int unsigned DW = 8;
    localparam int unsigned PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RD    = 2'd1,
        WAIT  = 2'd2,
        VALID = 2'd3
    } state_t;

    state_t          state;
    state_t          state_nx;
    logic [PW-1:0]   gnt_idx;
    logic            gnt_any;
    logic [CW-1:0]   count_nx;
    logic            q_read_en_nx;
    logic            pop_valid_nx;
    logic [DW-1:0]   pop_data_nx;

    assign full = (count == CW'(DEPTH));

`ifdef QARB_FIXED_PRIO_EN
    // Lowest set request index wins; descending scan so the lowest match is written last.
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        if (rst && !full) begin
            for (int i = NUM_REQ - 1; i >= 0; i--) begin
                if (req[i]) begin
                    gnt_any = 1'b1;
                    gnt_idx = PW'(i);
                end
            end
        end
    end
`else
    logic [PW-1:0] rr_ptr;
    logic [PW-1:0] cand;

    // Search from rr_ptr+1 with wrap; descending offsets so the nearest hit is written last.
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        cand    = '0;
        if (rst && !full) begin
            for (int k = NUM_REQ; k >= 1; k--) begin
                cand = PW'((32'(rr_ptr) + 32'(k)) % NUM_REQ);
                if (req[cand]) begin
                    gnt_any = 1'b1;
                    gnt_idx = cand;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_ptr <= PW'(NUM_REQ - 1);
        end else if (gnt_any) begin
            rr_ptr <= gnt_idx;
        end
    end
`endif

    assign gnt        = gnt_any ? (NUM_REQ'(1) << gnt_idx) : '0;
    assign q_write_en = gnt_any;
    assign q_in_data  = req_data[DW*32'(gnt_idx) +: DW];

    // Read sequencer: issue one read, wait out the queue latency, then present until acked.
    always_comb begin
        state_nx     = state;
        pop_valid_nx = pop_valid;
        pop_data_nx  = pop_data;
        case (state)
            IDLE: begin
                if (pop_req && (count != '0) && !q_empty) begin
                    state_nx = RD;
                end
            end
            RD: begin
                state_nx = WAIT;
            end
            WAIT: begin
                state_nx     = VALID;
                pop_valid_nx = 1'b1;
                pop_data_nx  = q_out_data;
            end
            VALID: begin
                if (pop_ack) begin
                    pop_valid_nx = 1'b0;
                    state_nx     = IDLE;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
        q_read_en_nx = (state_nx == RD);
    end

    // Occupancy: simultaneous write and read cancel; saturate at both ends.
    always_comb begin
        count_nx = count;
        if (q_write_en && !q_read_en) begin
            if (count != CW'(DEPTH)) begin
                count_nx = count + CW'(1);
            end
        end else if (!q_write_en && q_read_en) begin
            if (count != '0) begin
                count_nx = count - CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            count     <= '0;
            q_read_en <= 1'b0;
            pop_valid <= 1'b0;
            pop_data  <= '0;
        end else begin
            state     <= state_nx;
            count     <= count_nx;
            q_read_en <= q_read_en_nx;
            pop_valid <= pop_valid_nx;
            pop_data  <= pop_data_nx;
        end
    end

endmodule

// File: tb/tb_queue_arbiter.sv
// Bench for queue_arbiter: a FIFO queue model with 1-cycle read latency plus a
// transaction-level reference (grant search, occupancy, popped-data scoreboard).
module tb_queue_arbiter;

    localparam int NR    = 4;
    localparam int DEPTH = 8;
    localparam int CW    = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic [NR-1:0]     req;
    logic [7:0]        rd_arr [NR];
    logic [NR*8-1:0]   req_data;
    logic [NR-1:0]     gnt;
    logic [7:0]        q_in_data;
    logic              q_write_en;
    logic              q_read_en;
    logic [7:0]        q_out_data;
    logic              q_empty;
    logic              pop_req;
    logic              pop_valid;
    logic [7:0]        pop_data;
    logic              pop_ack;
    logic [CW-1:0]     count;
    logic              full;

    int total = 0;
    int bad   = 0;

    queue_arbiter #(.NUM_REQ(NR), .DEPTH(DEPTH), .CW(CW)) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .req_data   (req_data),
        .gnt        (gnt),
        .q_in_data  (q_in_data),
        .q_write_en (q_write_en),
        .q_read_en  (q_read_en),
        .q_out_data (q_out_data),
        .q_empty    (q_empty),
        .pop_req    (pop_req),
        .pop_valid  (pop_valid),
        .pop_data   (pop_data),
        .pop_ack    (pop_ack),
        .count      (count),
        .full       (full)
    );

    always #5 clk = ~clk;

    assign req_data = {rd_arr[3], rd_arr[2], rd_arr[1], rd_arr[0]};

    // Queue model: samples its controls at the falling edge, acts at the rising edge.
    logic [7:0] qmem [$];
    int         qn = 0;
    logic       force_empty = 1'b0;
    logic       wr_s, rd_s;
    logic [7:0] din_s;

    assign q_empty = (qn == 0) || force_empty;

    always @(negedge clk) begin
        wr_s  = q_write_en;
        rd_s  = q_read_en;
        din_s = q_in_data;
    end

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            qmem.delete();
            q_out_data <= '0;
            qn         <= 0;
        end else begin
            if (rd_s && qmem.size() != 0) q_out_data <= qmem.pop_front();
            if (wr_s) qmem.push_back(din_s);
            qn <= qmem.size();
        end
    end

    // Reference state
    int         m_count;
    int         m_rr;
    int         m_stage;     // cycles into the current pop: 0 none, 1 read issued, 2 data returning, 3 presented
    logic       m_pv;
    logic [7:0] m_pd;
    logic [7:0] m_exp;
    logic [7:0] sb [$];
    int         m_last_g;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_count  = 0;
        m_rr     = NR - 1;
        m_stage  = 0;
        m_pv     = 1'b0;
        m_pd     = '0;
        m_exp    = '0;
        m_last_g = -1;
        sb.delete();
    endtask

    // Check one cycle against the reference, then advance the reference across the edge.
    task automatic tick();
        int         eg;
        int         idx;
        logic [NR-1:0] eg_v;
        bit         e_empty;
        #1;
        eg = -1;
        if (m_count < DEPTH) begin
`ifdef QARB_FIXED_PRIO_EN
            for (int i = 0; i < NR; i++)
                if (eg < 0 && req[2'(i)]) eg = i;
`else
            for (int k = 1; k <= NR; k++) begin
                idx = (m_rr + k) % NR;
                if (eg < 0 && req[2'(idx)]) eg = idx;
            end
`endif
        end
        eg_v = '0;
        if (eg >= 0) eg_v[2'(eg)] = 1'b1;
        chk("gnt", 32'(gnt), 32'(eg_v));
        chk("write_en", 32'(q_write_en), 32'(eg >= 0));
        if (eg >= 0) chk("in_data", 32'(q_in_data), 32'(rd_arr[2'(eg)]));
        chk("count", 32'(count), 32'(m_count));
        chk("full", 32'(full), 32'(m_count == DEPTH));
        chk("read_en", 32'(q_read_en), 32'(m_stage == 1));
        chk("pop_valid", 32'(pop_valid), 32'(m_pv));
        chk("pop_data", 32'(pop_data), 32'(m_pd));
        e_empty = (sb.size() == 0) || force_empty;
        @(posedge clk);
        case (m_stage)
            0: if (pop_req && m_count != 0 && !e_empty) m_stage = 1;
            1: begin
                m_exp   = sb.pop_front();
                m_count = m_count - 1;
                m_stage = 2;
            end
            2: begin
                m_pv    = 1'b1;
                m_pd    = m_exp;
                m_stage = 3;
            end
            default: if (pop_ack) begin
                m_pv    = 1'b0;
                m_stage = 0;
            end
        endcase
        if (eg >= 0) begin
            sb.push_back(rd_arr[2'(eg)]);
            m_count = m_count + 1;
            m_rr    = eg;
        end
        m_last_g = eg;
        #1;
    endtask

    task automatic drop_granted();
        if (m_last_g >= 0) req[2'(m_last_g)] = 1'b0;
    endtask

    task automatic drain();
        req     = '0;
        pop_req = 1'b1;
        pop_ack = 1'b1;
        for (int i = 0; i < 80; i++) begin
            tick();
            if (m_count == 0 && m_stage == 0) break;
        end
        pop_req = 1'b0;
        chk("drained_count", 32'(count), 32'd0);
    endtask

    initial begin
        rst     = 1'b0;
        req     = '0;
        pop_req = 1'b0;
        pop_ack = 1'b0;
        for (int i = 0; i < NR; i++) rd_arr[i] = 8'hA0 + 8'(i);
        model_reset();

        // Reset state
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_read_en", 32'(q_read_en), 32'd0);
        chk("rst_pop_valid", 32'(pop_valid), 32'd0);
        chk("rst_pop_data", 32'(pop_data), 32'd0);
        rst = 1'b1;

        // All requesters held: rotating grants until full
        req = 4'b1111;
        for (int i = 0; i < 11; i++) tick();
        chk("fill_full", 32'(full), 32'd1);
        chk("fill_gnt", 32'(gnt), 32'd0);
        drain();

        // Two entries 07 then 01, popped in order with ack always high
        rd_arr[0] = 8'h07;
        rd_arr[1] = 8'h01;
        req = 4'b0011;
        tick(); drop_granted();
        tick(); drop_granted();
        chk("two_count", 32'(count), 32'd2);
        drain();
        chk("two_last", 32'(pop_data), 32'h01);

        // Simultaneous write and read at count 3
        rd_arr[0] = 8'h10; rd_arr[1] = 8'h11; rd_arr[2] = 8'h12; rd_arr[3] = 8'h33;
        req = 4'b0111;
        for (int i = 0; i < 3; i++) begin tick(); drop_granted(); end
        pop_req = 1'b1;
        pop_ack = 1'b0;
        tick();
        pop_req = 1'b0;
        req[3]  = 1'b1;
        tick(); drop_granted();
        #1;
        chk("rw_count", 32'(count), 32'd3);
        #1;
        for (int i = 0; i < 3; i++) tick();
        pop_ack = 1'b1;
        tick();
        drain();

        // Empty: pop_req must not issue a read; then 55 flows through
        pop_req = 1'b1;
        pop_ack = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        chk("empty_read_en", 32'(q_read_en), 32'd0);
        rd_arr[2] = 8'h55;
        req[2] = 1'b1;
        tick(); drop_granted();
        for (int i = 0; i < 3; i++) tick();
        chk("pop55_valid", 32'(pop_valid), 32'd1);
        chk("pop55_data", 32'(pop_data), 32'h55);
        drain();

        // Occupancy says non-empty but queue reports empty: no read
        req = 4'b0011;
        tick(); drop_granted();
        tick(); drop_granted();
        force_empty = 1'b1;
        pop_req = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        chk("mismatch_read_en", 32'(q_read_en), 32'd0);
        force_empty = 1'b0;
        drain();

        // Random traffic with a mid-run asynchronous reset
        for (int n = 0; n < 400; n++) begin
            if (n == 200) begin
                req = 4'b1111;
                pop_req = 1'b1;
                #2;
                rst = 1'b0;
                #1;
                chk("midrst_count", 32'(count), 32'd0);
                chk("midrst_pop_valid", 32'(pop_valid), 32'd0);
                chk("midrst_gnt", 32'(gnt), 32'd0);
                chk("midrst_read_en", 32'(q_read_en), 32'd0);
                req = '0;
                pop_req = 1'b0;
                @(posedge clk);
                #1;
                rst = 1'b1;
                model_reset();
            end
            for (int i = 0; i < NR; i++) begin
                if (m_last_g == i || !req[2'(i)]) begin
                    req[2'(i)] = 1'($urandom_range(0, 1));
                    rd_arr[i]  = 8'($urandom);
                end
            end
            pop_req = 1'($urandom_range(0, 1));
            pop_ack = ($urandom_range(0, 3) != 0);
            tick();
        end
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
